// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if: I-side/D-side memory handshake between pipeline and hazard controller
interface hazard_control_unit_if;
  logic imem_req;
  logic imem_resp;
  logic dmem_req;
  logic dmem_resp;
  logic imem_read;
  logic dmem_access;
  logic imem_capture;
  logic dmem_capture;
  modport master (
    output imem_req, imem_resp, dmem_req, dmem_resp,
    input  imem_read, dmem_access, imem_capture, dmem_capture
  );
  modport slave (
    input  imem_req, imem_resp, dmem_req, dmem_resp,
    output imem_read, dmem_access, imem_capture, dmem_capture
  );
endinterface

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use bubbles, memory-wait freeze, redirect flush and perf counters
module hazard_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           i_id_rs1,
  input  logic [4:0]           i_id_rs2,
  input  logic                 i_id_uses_rs1,
  input  logic                 i_id_uses_rs2,
  input  logic [4:0]           i_ex_rd,
  input  logic                 i_ex_is_load,
  input  logic                 i_ex_br_taken,
  hazard_control_unit_if.slave mem,
  output logic                 o_freeze,
  output logic                 o_pc_stall,
  output logic                 o_if_id_stall,
  output logic                 o_if_id_flush,
  output logic                 o_id_ex_bubble,
  output logic [CNT_W-1:0]     o_loaduse_cnt,
  output logic [CNT_W-1:0]     o_memwait_cnt,
  output logic [CNT_W-1:0]     o_flush_cnt
);
  typedef enum logic {RUN, WAIT} state_t;
  state_t r_state;
  state_t w_state_nx;
  logic r_i_done;
  logic r_d_done;
  logic w_i_done_nx;
  logic w_d_done_nx;
  logic w_i_ok;
  logic w_d_ok;
  logic w_adv;
  logic w_lu;
  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_mw_cnt;
  logic [CNT_W-1:0] r_fl_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_i_done <= w_i_done_nx;
      r_d_done <= w_d_done_nx;
    end
  end
  always_comb begin
    w_i_ok      = !mem.imem_req | mem.imem_resp | r_i_done;
    w_d_ok      = !mem.dmem_req | mem.dmem_resp | r_d_done;
    w_adv       = w_i_ok & w_d_ok;
    w_state_nx  = w_adv ? RUN : WAIT;
    w_i_done_nx = !w_adv & ((r_state == WAIT & r_i_done) | (mem.imem_resp & mem.imem_req));
    w_d_done_nx = !w_adv & ((r_state == WAIT & r_d_done) | (mem.dmem_resp & mem.dmem_req));
  end
  always_comb begin
    w_lu = i_ex_is_load & (i_ex_rd != 5'd0) &
           ((i_id_uses_rs1 & (i_id_rs1 == i_ex_rd)) | (i_id_uses_rs2 & (i_id_rs2 == i_ex_rd)));
    mem.imem_read    = mem.imem_req & !r_i_done;
    mem.dmem_access  = mem.dmem_req & !r_d_done;
    mem.imem_capture = mem.imem_resp & !w_adv;
    mem.dmem_capture = mem.dmem_resp & !w_adv;
    o_freeze         = !w_adv;
    o_pc_stall       = !w_adv | (!i_ex_br_taken & w_lu);
    o_if_id_stall    = !w_adv | (!i_ex_br_taken & w_lu);
    o_if_id_flush    = w_adv & i_ex_br_taken;
    o_id_ex_bubble   = w_adv & (i_ex_br_taken | w_lu);
    o_loaduse_cnt    = r_lu_cnt;
    o_memwait_cnt    = r_mw_cnt;
    o_flush_cnt      = r_fl_cnt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lu_cnt <= '0;
      r_mw_cnt <= '0;
      r_fl_cnt <= '0;
    end else begin
      r_mw_cnt <= (!w_adv && r_mw_cnt != '1) ? r_mw_cnt + CNT_W'(1) : r_mw_cnt;
      r_lu_cnt <= (w_adv && !i_ex_br_taken && w_lu && r_lu_cnt != '1) ? r_lu_cnt + CNT_W'(1) : r_lu_cnt;
      r_fl_cnt <= (w_adv && i_ex_br_taken && r_fl_cnt != '1) ? r_fl_cnt + CNT_W'(1) : r_fl_cnt;
    end
  end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: table, directed and randomized checks against a behavioural model
module tb_hazard_control_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic [4:0] rs1, rs2, ex_rd;
  logic u1, u2, ld, br;
  logic frz, pcs, ifs, fl, bub;
  logic [31:0] lu_c, mw_c, fl_c;
  logic frz2, pcs2, ifs2, fl2, bub2;
  logic [2:0] lu2, mw2, fls2;
  hazard_control_unit_if bus();
  hazard_control_unit_if bus2();
  assign bus2.imem_req  = bus.imem_req;
  assign bus2.imem_resp = bus.imem_resp;
  assign bus2.dmem_req  = bus.dmem_req;
  assign bus2.dmem_resp = bus.dmem_resp;
  hazard_control_unit dut (
    .clk(clk), .rst(rst), .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_uses_rs1(u1), .i_id_uses_rs2(u2),
    .i_ex_rd(ex_rd), .i_ex_is_load(ld), .i_ex_br_taken(br), .mem(bus.slave),
    .o_freeze(frz), .o_pc_stall(pcs), .o_if_id_stall(ifs), .o_if_id_flush(fl), .o_id_ex_bubble(bub),
    .o_loaduse_cnt(lu_c), .o_memwait_cnt(mw_c), .o_flush_cnt(fl_c)
  );
  hazard_control_unit #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_uses_rs1(u1), .i_id_uses_rs2(u2),
    .i_ex_rd(ex_rd), .i_ex_is_load(ld), .i_ex_br_taken(br), .mem(bus2.slave),
    .o_freeze(frz2), .o_pc_stall(pcs2), .o_if_id_stall(ifs2), .o_if_id_flush(fl2), .o_id_ex_bubble(bub2),
    .o_loaduse_cnt(lu2), .o_memwait_cnt(mw2), .o_flush_cnt(fls2)
  );
  typedef struct {
    string name;
    logic [4:0] rs1, rs2, ex_rd;
    logic u1, u2, ld, br, ireq, iresp, dreq, dresp;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[10];
  int vectors = 0;
  int miscompares = 0;
  bit m_ig, m_dg;
  longint m_lu, m_mw, m_fl;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [8:0] act_out();
    return {bus.imem_read, bus.dmem_access, bus.imem_capture, bus.dmem_capture, frz, pcs, ifs, fl, bub};
  endfunction
  function automatic logic [8:0] model_out();
    bit lu = ld && ex_rd != 0 && ((u1 && rs1 == ex_rd) || (u2 && rs2 == ex_rd));
    bit i_pending = bus.imem_req && !bus.imem_resp && !m_ig;
    bit d_pending = bus.dmem_req && !bus.dmem_resp && !m_dg;
    bit stall = i_pending || d_pending;
    logic [8:0] o;
    o[8] = bus.imem_req && !m_ig;
    o[7] = bus.dmem_req && !m_dg;
    o[6] = bus.imem_resp && stall;
    o[5] = bus.dmem_resp && stall;
    o[4] = stall;
    if (stall) o[3:0] = 4'b1100;
    else if (br) o[3:0] = 4'b0011;
    else if (lu) o[3:0] = 4'b1101;
    else o[3:0] = 4'b0000;
    return o;
  endfunction
  function automatic longint sat7(input longint v);
    return v > 7 ? 7 : v;
  endfunction
  task automatic step(input string tag);
    logic [8:0] e;
    e = model_out();
    #1;
    chk({tag, " outs"}, act_out(), e);
    chk({tag, " loaduse_cnt"}, lu_c, m_lu);
    chk({tag, " memwait_cnt"}, mw_c, m_mw);
    chk({tag, " flush_cnt"}, fl_c, m_fl);
    chk({tag, " sat loaduse"}, lu2, sat7(m_lu));
    chk({tag, " sat memwait"}, mw2, sat7(m_mw));
    chk({tag, " sat flush"}, fls2, sat7(m_fl));
    if (rst) begin
      m_ig = 0; m_dg = 0; m_lu = 0; m_mw = 0; m_fl = 0;
    end else if (e[4]) begin
      m_mw++;
      m_ig = m_ig || (bus.imem_req && bus.imem_resp);
      m_dg = m_dg || (bus.dmem_req && bus.dmem_resp);
    end else begin
      m_ig = 0; m_dg = 0;
      if (e[1]) m_fl++;
      else if (e[0]) m_lu++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic set_vec(input vec_t v);
    rs1 = v.rs1; rs2 = v.rs2; u1 = v.u1; u2 = v.u2; ex_rd = v.ex_rd; ld = v.ld; br = v.br;
    bus.imem_req = v.ireq; bus.imem_resp = v.iresp; bus.dmem_req = v.dreq; bus.dmem_resp = v.dresp;
  endtask
  task automatic zero_in();
    rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; ex_rd = 0; ld = 0; br = 0;
    bus.imem_req = 0; bus.imem_resp = 0; bus.dmem_req = 0; bus.dmem_resp = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    zero_in();
    step("rst");
    rst = 0;
  endtask
  initial begin
    tbl[0] = '{"lu rs1",        5'd5, 5'd0, 5'd5, 1, 0, 1, 0, 1, 1, 0, 0, 9'b1_0_0_0_0_1_1_0_1};
    tbl[1] = '{"x0 no lu",      5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 1, 1, 0, 0, 9'b1_0_0_0_0_0_0_0_0};
    tbl[2] = '{"br over lu",    5'd5, 5'd0, 5'd5, 1, 0, 1, 1, 1, 1, 0, 0, 9'b1_0_0_0_0_0_0_1_1};
    tbl[3] = '{"rs2 unused",    5'd3, 5'd5, 5'd5, 1, 0, 1, 0, 1, 1, 0, 0, 9'b1_0_0_0_0_0_0_0_0};
    tbl[4] = '{"not load",      5'd5, 5'd0, 5'd5, 1, 0, 0, 0, 1, 1, 0, 0, 9'b1_0_0_0_0_0_0_0_0};
    tbl[5] = '{"freeze wins",   5'd5, 5'd0, 5'd5, 1, 0, 1, 1, 1, 0, 0, 0, 9'b1_0_0_0_1_1_1_0_0};
    tbl[6] = '{"dwait icap",    5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1, 1, 0, 9'b1_1_1_0_1_1_1_0_0};
    tbl[7] = '{"stray resp",    5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 1, 9'b0_0_0_0_0_0_0_0_0};
    tbl[8] = '{"dmem hit",      5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 1, 9'b0_1_0_0_0_0_0_0_0};
    tbl[9] = '{"lu both",       5'd7, 5'd7, 5'd7, 1, 1, 1, 0, 1, 1, 1, 1, 9'b1_1_0_0_0_1_1_0_1};
    rst = 1;
    zero_in();
    @(posedge clk);
    @(negedge clk);
    m_ig = 0; m_dg = 0; m_lu = 0; m_mw = 0; m_fl = 0;
    #1;
    chk("reset outs", act_out(), 9'b0_0_0_0_0_0_0_0_0);
    chk("reset counters", {lu_c, mw_c}, 64'd0);
    do_reset();
    foreach (tbl[k]) begin
      do_reset();
      set_vec(tbl[k]);
      #1;
      chk(tbl[k].name, act_out(), tbl[k].exp);
      step(tbl[k].name);
    end
    do_reset();
    set_vec(tbl[0]);
    step("lu seq");
    ld = 0;
    #1 chk("lu one bubble", bub, 1'b0);
    chk("lu count", lu_c, 32'd1);
    step("lu seq2");
    do_reset();
    bus.imem_req = 1; bus.dmem_req = 1;
    step("mw c0");
    bus.imem_resp = 1;
    #1 chk("mw icap", bus.imem_capture, 1'b1);
    step("mw c1");
    bus.imem_resp = 0;
    #1 chk("mw iread drop", bus.imem_read, 1'b0);
    step("mw c2");
    step("mw c3");
    bus.dmem_resp = 1;
    #1 chk("mw release", frz, 1'b0);
    step("mw c4");
    chk("mw count", mw_c, 32'd4);
    zero_in();
    step("mw idle");
    do_reset();
    bus.imem_req = 1; br = 1;
    for (int c = 0; c < 3; c++) begin
      #1 chk("br held", fl, 1'b0);
      step("br frz");
    end
    bus.imem_resp = 1;
    #1 chk("br release", fl, 1'b1);
    step("br rel");
    zero_in();
    #1 chk("br once", fl, 1'b0);
    chk("br count", fl_c, 32'd1);
    step("br after");
    do_reset();
    bus.imem_req = 1; bus.dmem_req = 1;
    step("rw c0");
    bus.dmem_resp = 1;
    step("rw c1");
    bus.dmem_resp = 0;
    #1 chk("rw d_done", bus.dmem_access, 1'b0);
    step("rw c2");
    rst = 1;
    step("rw rst");
    rst = 0;
    #1 chk("rw reaccess", bus.dmem_access, 1'b1);
    chk("rw cnt clear", mw_c, 32'd0);
    step("rw c3");
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      u1 = 1'($urandom);
      u2 = 1'($urandom);
      ld = 1'($urandom);
      br = ($urandom_range(0, 5) == 0);
      bus.imem_req = ($urandom_range(0, 3) != 0);
      bus.dmem_req = ($urandom_range(0, 2) == 0);
      bus.imem_resp = bus.imem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      bus.dmem_resp = bus.dmem_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      step("rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Producer-side hazard controller for the 5-stage RV32I pipeline, complementing EX-stage operand forwarding. It detects load-use hazards forwarding cannot cover, inserts one ID/EX bubble, and freezes the whole pipeline while I-side or D-side memory responses are outstanding. It also flushes wrong-path instructions on a taken branch/jump resolved in EX and keeps saturating performance counters. It sits beside the pipeline registers and drives their load/flush controls and the cache request qualifiers.

Parameters:
CNT_W, 32, width of each saturating performance counter

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous active-high reset
id_rs1  in  5  rs1 of instruction in IF/ID
id_rs2  in  5  rs2 of instruction in IF/ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  rd of instruction in ID/EX
ex_is_load  in  1  ID/EX instruction is a load
ex_br_taken  in  1  EX resolved a redirect (taken branch, jal, jalr)
imem_req  in  1  fetch needs an instruction this cycle
imem_resp  in  1  I-cache response, 1-cycle pulse
dmem_req  in  1  EX/MEM stage holds a load/store
dmem_resp  in  1  D-cache response, 1-cycle pulse
imem_read  out  1  qualified I-cache read strobe
dmem_access  out  1  qualified D-cache read/write strobe
imem_capture  out  1  fetch buffer latches I-cache rdata
dmem_capture  out  1  MEM stage latches D-cache rdata
freeze  out  1  hold PC and all pipeline registers
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  load NOP into IF/ID
id_ex_bubble  out  1  load NOP into ID/EX
loaduse_cnt  out  CNT_W  load-use bubble cycles
memwait_cnt  out  CNT_W  freeze cycles
flush_cnt  out  CNT_W  redirect flushes

Behaviour:
- States RUN, WAIT. Sticky flags i_done, d_done.
- i_ok = !imem_req | imem_resp | i_done; d_ok = !dmem_req | dmem_resp | d_done; advance = i_ok & d_ok.
- RUN: if advance, stay RUN. Otherwise go to WAIT, with i_done <= imem_resp & imem_req and d_done <= dmem_resp & dmem_req.
- WAIT: i_done |= imem_resp; d_done |= dmem_resp; when advance, go to RUN and clear both flags.
- imem_read = imem_req & !i_done; dmem_access = dmem_req & !d_done. No re-request once a response is captured.
- imem_capture = imem_resp & !advance; dmem_capture = dmem_resp & !advance. The held datum is used on the release cycle.
- freeze = !advance (combinational). Freeze overrides every other output: pc_stall = if_id_stall = 1, if_id_flush = id_ex_bubble = 0.
- Load-use (lu) = ex_is_load & ex_rd != 0 & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- Priority on advancing cycles:
  - ex_br_taken: if_id_flush = 1, id_ex_bubble = 1, no stall.
  - else lu: pc_stall = 1, if_id_stall = 1, id_ex_bubble = 1.
  - else all outputs 0.
- Redirect during freeze is deferred. ex_br_taken stays held with ID/EX, so the flush fires exactly on the release cycle.
- lu produces exactly one bubble per load: the next advance moves the load to MEM, where it is covered by MEM/WB forwarding.
- Counters (all reset to 0, saturate at all-ones):
  - memwait_cnt +1 each freeze cycle.
  - loaduse_cnt +1 each advancing lu cycle without ex_br_taken.
  - flush_cnt +1 each advancing ex_br_taken cycle.
- Reset: state RUN, flags 0, counters 0. rst mid-WAIT aborts immediately; outputs follow the reset state next cycle. Responses arriving in the reset cycle are ignored.
- imem_resp/dmem_resp without a matching req are ignored (no flag set).

Test Plan:
- lw x5 in EX (ex_rd=5, ex_is_load=1), ID add uses rs1=5, all responses immediate -> one cycle of pc_stall=if_id_stall=id_ex_bubble=1, loaduse_cnt=1; next cycle all 0.
- Same lw, but ID uses rs2=0 with ex_rd=0 -> no stall, loaduse_cnt=0.
- dmem_req=1, dmem_resp after 4 cycles, imem_resp at cycle 1 -> freeze for 4 cycles, imem_capture pulses at cycle 1, imem_read drops from cycle 2, memwait_cnt=4, released on the dmem_resp cycle.
- ex_br_taken=1 together with lu=1 -> if_id_flush=id_ex_bubble=1, pc_stall=0, flush_cnt=1, loaduse_cnt=0.
- ex_br_taken=1 during a 3-cycle freeze -> flush outputs 0 for 3 cycles, then asserted for exactly one cycle on release.
- rst asserted in WAIT with d_done=1 -> next cycle state RUN, flags clear, counters 0, dmem_access re-asserts if dmem_req=1.
